pipe_buffer: RTL

Parametrised, elastic inter-stage buffer for the in-order core pipeline. It replaces the fixed per-stage registers that carry fetch, decode, execute and memory payloads. It holds up to DEPTH opaque payload words behind a valid/ready handshake on each side, supports single-cycle flush for branch/exception redirect, and keeps full throughput when the downstream stage is ready. One instance sits between each pair of adjacent stages, with DATA_W set to the bit width of that stage's payload struct.

---
 rtl/pipe_buffer_pkg.sv | 43 ++++
 rtl/pipe_buffer_mem.sv | 50 +++++
 rtl/pipe_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_buffer_pkg.sv
// ============================================================================
// Module      : pipe_buffer_pkg
// Description : Shared constants and stage payload structs for pipe_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_buffer_pkg;

    localparam int PIPE_BUF_MIN_DEPTH = 1;
    localparam int PIPE_BUF_MAX_DEPTH = 8;

    // Stage payloads; DATA_W of each instance is the $bits of one of these
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [7:0]  op;
    } decode_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        mem_en;
        logic        mem_we;
    } execute_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wb_val;
        logic        wb_en;
    } memory_payload_t;

endpackage

`default_nettype wire

// File: rtl/pipe_buffer_mem.sv
// ============================================================================
// Module      : pipe_buffer_mem
// Description : DEPTH x DATA_W register array, one write port, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_buffer_mem
    import pipe_buffer_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    generate
        if (DEPTH == 1) begin : g_single
            // A single entry needs no address decode
            logic [DATA_W-1:0] r_entry;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_entry <= wr_data;
                end
            end

            assign rd_data = r_entry;
        end else begin : g_multi
            logic [DATA_W-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_mem[wr_addr] <= wr_data;
                end
            end

            assign rd_data = r_mem[rd_addr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pipe_buffer.sv
// ============================================================================
// Module      : pipe_buffer
// Description : Elastic valid/ready inter-stage buffer with single-cycle flush.
//               Define PIPE_BUFFER_BYPASS_EN for zero-latency empty bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_buffer
    import pipe_buffer_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    generate
        if (DEPTH < PIPE_BUF_MIN_DEPTH || DEPTH > PIPE_BUF_MAX_DEPTH) begin : g_bad_depth
            $error("pipe_buffer: DEPTH out of legal range");
        end
    endgenerate

    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_empty;
    logic               w_bypass;
    logic               w_pop;
    logic               w_push;
    logic               w_store;
    logic               w_drain;

    assign w_empty = (r_count == '0);

`ifdef PIPE_BUFFER_BYPASS_EN
    assign w_bypass = w_empty && in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign in_ready  = (r_count != c_cnt_full) || out_ready;
    assign out_valid = (!w_empty || w_bypass) && !flush;
    assign out_data  = w_bypass ? in_data : w_rd_data;
    assign count     = r_count;

    assign w_pop  = out_valid && out_ready;
    assign w_push = in_valid && in_ready && !flush;
    // A bypassed payload taken downstream is never written nor read back
    assign w_store = w_push && !(w_bypass && out_ready);
    assign w_drain = w_pop && !w_bypass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_drain) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
            end
            case ({w_store, w_drain})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    pipe_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (c_ptr_w)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_store),
        .wr_addr (r_wr_ptr),
        .wr_data (in_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

endmodule

`default_nettype wire
